// File: rtl/ula_pkg.sv
// Shared ULA definitions: slice width and the serial-subtractor FSM states.
package ula_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sub_state_t;

endpackage

// File: rtl/subtrador.sv
// 4-bit ripple-borrow subtractor: s = a - b - cin, cout = borrow out of bit 3.
// Ports:
//   a, b  : 4-bit minuend / subtrahend
//   cin   : borrow in (1 = subtract one more)
//   s     : 4-bit difference
//   cout  : borrow out
module subtrador
    import ula_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout
);

    logic [NIBBLE_W:0] brw_c;

    // Full-subtractor chain; borrow propagates when a==b at a bit.
    always_comb begin
        brw_c    = '0;
        s        = '0;
        brw_c[0] = cin;
        for (int i = 0; i < int'(NIBBLE_W); i++) begin
            s[i]       = a[i] ^ b[i] ^ brw_c[i];
            brw_c[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw_c[i]);
        end
    end

    assign cout = brw_c[NIBBLE_W];

endmodule

// File: rtl/subtrador_serial_ctrl.sv
// Nibble-serial multi-word subtraction sequencer.
// Accepts op_a/op_b/bin on a valid/ready handshake, runs one nibble per cycle
// (LSB first) through a single 4-bit subtractor with a registered borrow chain,
// then presents diff/bout/zero/ovf on a second valid/ready handshake.
// Ports:
//   clk, rst_n               : clock, synchronous active-low reset
//   start_valid/start_ready  : operand handshake
//   op_a, op_b, bin          : minuend, subtrahend, borrow-in (sampled on accept)
//   res_valid/res_ready      : result handshake
//   diff, bout, zero, ovf    : op_a-op_b-bin mod 2^W, borrow-out, diff==0, signed overflow
module subtrador_serial_ctrl
    import ula_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_valid,
    output logic                         start_ready,
    input  logic [NIBBLES*NIBBLE_W-1:0]  op_a,
    input  logic [NIBBLES*NIBBLE_W-1:0]  op_b,
    input  logic                         bin,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [NIBBLES*NIBBLE_W-1:0]  diff,
    output logic                         bout,
    output logic                         zero,
    output logic                         ovf
);

    localparam int unsigned CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

    typedef logic [NIBBLES-1:0][NIBBLE_W-1:0] word_t;

    sub_state_t       state_q, state_d;
    word_t            a_q, a_d;
    word_t            b_q, b_d;
    word_t            diff_q, diff_d;
    logic             brw_q, brw_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bout_q, bout_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             start_ready_q;
    logic             res_valid_q;

    logic [NIBBLE_W-1:0] slice_s;
    logic                slice_cout;

    // Single shared slice; operands selected by the nibble counter.
    subtrador u_slice (
        .a    (a_q[cnt_q]),
        .b    (b_q[cnt_q]),
        .cin  (brw_q),
        .s    (slice_s),
        .cout (slice_cout)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        brw_d   = brw_q;
        cnt_d   = cnt_q;
        bout_d  = bout_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (start_valid && start_ready_q) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    brw_d   = bin;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                diff_d[cnt_q] = slice_s;
                brw_d         = slice_cout;
                cnt_d         = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    // Flags are taken from diff_d so the final nibble is included.
                    state_d = DONE;
                    bout_d  = slice_cout;
                    zero_d  = (diff_d == '0);
                    ovf_d   = (a_q[NIBBLES-1][NIBBLE_W-1] ^ b_q[NIBBLES-1][NIBBLE_W-1])
                            & (a_q[NIBBLES-1][NIBBLE_W-1] ^ diff_d[NIBBLES-1][NIBBLE_W-1]);
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; handshake flags track the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            a_q           <= '0;
            b_q           <= '0;
            diff_q        <= '0;
            brw_q         <= 1'b0;
            cnt_q         <= '0;
            bout_q        <= 1'b0;
            zero_q        <= 1'b0;
            ovf_q         <= 1'b0;
            start_ready_q <= 1'b1;
            res_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            diff_q        <= diff_d;
            brw_q         <= brw_d;
            cnt_q         <= cnt_d;
            bout_q        <= bout_d;
            zero_q        <= zero_d;
            ovf_q         <= ovf_d;
            start_ready_q <= (state_d == IDLE);
            res_valid_q   <= (state_d == DONE);
        end
    end

    assign start_ready = start_ready_q;
    assign res_valid   = res_valid_q;
    assign diff        = diff_q;
    assign bout        = bout_q;
    assign zero        = zero_q;
    assign ovf         = ovf_q;

endmodule
